// File: rtl/mem_pkg.sv
// Shared types and geometry for the memory-side line fetcher: FSM state encoding,
// word/line widths and the bit offset of each word inside an assembled line.
package mem_pkg;

  localparam int WORD_W     = 16;
  localparam int LINE_WORDS = 4;
  localparam int LINE_W     = LINE_WORDS * WORD_W;
  localparam int CNT_W      = $clog2(LINE_WORDS);

  // Word k of a line lives at line[WORD_LO[k] +: WORD_W].
  localparam int WORD_LO [LINE_WORDS] = '{0 * WORD_W, 1 * WORD_W, 2 * WORD_W, 3 * WORD_W};

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_LAST  = 3'd2,
    HOLD     = 3'd3,
    WR       = 3'd4,
    WDONE    = 3'd5
  } mem_state_t;

endpackage

// File: rtl/mem_line_fetcher_line_assembler.sv
// Line buffer: LINE_WORDS registers of WORD_W bits, one written per cycle by index,
// presented side by side as a single cache line. Cleared by reset.
module line_assembler
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [CNT_W-1:0]  wr_idx,
  input  logic [WORD_W-1:0] wr_data,
  output logic [LINE_W-1:0] line
);

  logic [WORD_W-1:0] words [LINE_WORDS];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < LINE_WORDS; i++) begin
        words[i] <= '0;
      end
    end else if (wr_en) begin
      words[wr_idx] <= wr_data;
    end
  end

  for (genvar g = 0; g < LINE_WORDS; g++) begin : g_pack
    assign line[WORD_LO[g] +: WORD_W] = words[g];
  end

endmodule

// File: rtl/mem_line_fetcher.sv
// Memory-side controller below the cache: 4-word SRAM burst per line read, single-word
// write-through. Define MEM_STATS_EN to add the rd_count/wr_count request counters.
module mem_line_fetcher
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              readM,
  input  logic              writeM,
  input  logic [ADDR_W-1:0] addressM,
  inout  wire  [LINE_W-1:0] dataM,
  output logic              ready,
  output logic              protocol_err,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_we,
  output logic [WORD_W-1:0] sram_wdata,
  input  logic [WORD_W-1:0] sram_rdata,
`ifdef MEM_STATS_EN
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count,
`endif
  output logic [2:0]        state_dbg
);

  // Handshake: readM/writeM are level requests held by the cache until it sees ready;
  // ready stays high (line driven on dataM for reads) until the request drops, and the
  // request is only re-sampled after the FSM has spent a cycle back in IDLE.

  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(LINE_WORDS - 1);
  localparam logic [1:0]       WAIT_LAST = 2'(WAIT_STATES);

  mem_state_t        state;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        wcnt;
  logic [ADDR_W-1:0] aligned_addr;
  logic              cap_en;
  logic [CNT_W-1:0]  cap_idx;
  logic [LINE_W-1:0] line;
  logic              unused_data_hi;

  assign aligned_addr   = {addressM[ADDR_W-1:CNT_W], {CNT_W{1'b0}}};
  assign unused_data_hi = ^dataM[LINE_W-1:WORD_W];
  assign state_dbg      = state;

  // SRAM data trails the address by one cycle, so the word for address cnt-1 is
  // captured on the first cycle of each access period.
  always_comb begin
    cap_en  = 1'b0;
    cap_idx = LAST_IDX;
    if (state == RD_LAST) begin
      cap_en = 1'b1;
    end else if (state == RD_ISSUE && wcnt == 2'd0 && cnt != '0) begin
      cap_en  = 1'b1;
      cap_idx = cnt - CNT_W'(1);
    end
  end

  line_assembler u_line (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (cap_en),
    .wr_idx  (cap_idx),
    .wr_data (sram_rdata),
    .line    (line)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      ready        <= 1'b0;
      sram_we      <= 1'b0;
      sram_addr    <= '0;
      sram_wdata   <= '0;
      protocol_err <= 1'b0;
      base         <= '0;
      cnt          <= '0;
      wcnt         <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          ready <= 1'b0;
          if (writeM) begin
            sram_addr  <= addressM;
            sram_wdata <= dataM[WORD_W-1:0];
            sram_we    <= 1'b1;
            state      <= WR;
            if (readM) begin
              protocol_err <= 1'b1;
            end
          end else if (readM) begin
            base      <= aligned_addr;
            sram_addr <= aligned_addr;
            cnt       <= '0;
            wcnt      <= 2'd0;
            state     <= RD_ISSUE;
            if (addressM[CNT_W-1:0] != '0) begin
              protocol_err <= 1'b1;
            end
          end
        end
        RD_ISSUE: begin
          if (wcnt == WAIT_LAST) begin
            wcnt <= 2'd0;
            if (cnt == LAST_IDX) begin
              state <= RD_LAST;
            end else begin
              cnt       <= cnt + CNT_W'(1);
              sram_addr <= base + ADDR_W'(cnt) + ADDR_W'(1);
            end
          end else begin
            wcnt <= wcnt + 2'd1;
          end
        end
        RD_LAST: begin
          ready <= 1'b1;
          state <= HOLD;
        end
        HOLD: begin
          if (!readM) begin
            ready <= 1'b0;
            state <= IDLE;
          end
        end
        WR: begin
          sram_we <= 1'b0;
          ready   <= 1'b1;
          state   <= WDONE;
        end
        WDONE: begin
          if (!writeM) begin
            ready <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          ready   <= 1'b0;
          sram_we <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign dataM = (state == HOLD) ? line : {LINE_W{1'bz}};

`ifdef MEM_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_count <= 16'h0000;
      wr_count <= 16'h0000;
    end else if (state == IDLE) begin
      if (writeM) begin
        if (wr_count != 16'hFFFF) begin
          wr_count <= wr_count + 16'h0001;
        end
      end else if (readM) begin
        if (rd_count != 16'hFFFF) begin
          rd_count <= rd_count + 16'h0001;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_line_fetcher.sv
// Bench for mem_line_fetcher: two instances (no wait states / two wait states) share
// stimulus; directed requests push expectations, a negedge monitor pops and compares.
module tb_mem_line_fetcher;
  import mem_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        read_m, write_m;
  logic [15:0] address_m;
  logic [15:0] tb_wdata;
  logic        tb_den;
  wire  [63:0] data_m0, data_m1;
  logic        ready0, ready1, perr0, perr1, we0, we1;
  logic [15:0] saddr0, saddr1, swdata0, swdata1, srdata0, srdata1;
  logic [2:0]  st0, st1;
`ifdef MEM_STATS_EN
  logic [15:0] rdc0, wrc0, rdc1, wrc1;
`endif

  assign data_m0 = tb_den ? {48'h0, tb_wdata} : {64{1'bz}};
  assign data_m1 = tb_den ? {48'h0, tb_wdata} : {64{1'bz}};

  mem_line_fetcher #(.ADDR_W(16), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .readM(read_m), .writeM(write_m), .addressM(address_m),
    .dataM(data_m0), .ready(ready0), .protocol_err(perr0), .sram_addr(saddr0),
    .sram_we(we0), .sram_wdata(swdata0), .sram_rdata(srdata0),
`ifdef MEM_STATS_EN
    .rd_count(rdc0), .wr_count(wrc0),
`endif
    .state_dbg(st0)
  );

  mem_line_fetcher #(.ADDR_W(16), .WAIT_STATES(2)) dut1 (
    .clk(clk), .reset_n(reset_n), .readM(read_m), .writeM(write_m), .addressM(address_m),
    .dataM(data_m1), .ready(ready1), .protocol_err(perr1), .sram_addr(saddr1),
    .sram_we(we1), .sram_wdata(swdata1), .sram_rdata(srdata1),
`ifdef MEM_STATS_EN
    .rd_count(rdc1), .wr_count(wrc1),
`endif
    .state_dbg(st1)
  );

  // ---------------- SRAM models (one per instance, identical preload) ----------------
  logic        pl_en;
  logic [15:0] pl_addr, pl_data;
  logic [15:0] mem0 [0:65535];
  logic [15:0] mem1 [0:65535];

  always @(posedge clk) begin
    if (pl_en) begin
      mem0[pl_addr] <= pl_data;
      mem1[pl_addr] <= pl_data;
    end else begin
      if (we0) mem0[saddr0] <= swdata0;
      if (we1) mem1[saddr1] <= swdata1;
    end
    srdata0 <= mem0[saddr0];
    srdata1 <= mem1[saddr1];
  end

  localparam logic [31:0] PL_TAB [13] = '{
    32'h0010_1111, 32'h0011_2222, 32'h0012_3333, 32'h0013_4444,
    32'h0020_A0A0, 32'h0021_A1A1, 32'h0022_A2A2, 32'h0023_A3A3,
    32'hFFFC_F0F0, 32'hFFFD_F1F1, 32'hFFFE_F2F2, 32'hFFFF_F3F3,
    32'h0000_0BAD
  };

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q0[$], exp_q1[$];
  logic [31:0] wexp_q0[$], wexp_q1[$];
  logic        wrap_watch;
  logic        prev_rdy0 = 1'b0, prev_rdy1 = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ready0 && !prev_rdy0 && st0 == HOLD) begin
      if (exp_q0.size() == 0) chk("line0_extra", 64'(exp_q0.size()), 64'd1);
      else chk("line0", data_m0, exp_q0.pop_front());
    end
    if (ready1 && !prev_rdy1 && st1 == HOLD) begin
      if (exp_q1.size() == 0) chk("line1_extra", 64'(exp_q1.size()), 64'd1);
      else chk("line1", data_m1, exp_q1.pop_front());
    end
    if (we0) begin
      if (wexp_q0.size() == 0) chk("we0_extra", 64'(wexp_q0.size()), 64'd1);
      else chk("sram_wr0", 64'({saddr0, swdata0}), 64'(wexp_q0.pop_front()));
    end
    if (we1) begin
      if (wexp_q1.size() == 0) chk("we1_extra", 64'(wexp_q1.size()), 64'd1);
      else chk("sram_wr1", 64'({saddr1, swdata1}), 64'(wexp_q1.pop_front()));
    end
    if (wrap_watch && (st0 == RD_ISSUE || st0 == RD_LAST)) chk("wrap_addr0", 64'(saddr0[15:2]), 64'h3FFF);
    if (wrap_watch && (st1 == RD_ISSUE || st1 == RD_LAST)) chk("wrap_addr1", 64'(saddr1[15:2]), 64'h3FFF);
    prev_rdy0 <= ready0;
    prev_rdy1 <= ready1;
  end

  // ---------------- driver tasks (all start and end on a negedge) ----------------
  task automatic apply_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic do_read(input logic [15:0] addr, input logic [63:0] exp);
    int n = 0;
    int lat0 = -1;
    int lat1 = -1;
    exp_q0.push_back(exp);
    exp_q1.push_back(exp);
    address_m = addr;
    read_m    = 1'b1;
    while ((lat0 < 0 || lat1 < 0) && n < 60) begin
      @(negedge clk);
      n++;
      if (n == 1) address_m = 16'hDEAD;
      if (ready0 && lat0 < 0) lat0 = n - 1;
      if (ready1 && lat1 < 0) lat1 = n - 1;
    end
    chk("rd_lat0", 64'(lat0), 64'd5);
    chk("rd_lat1", 64'(lat1), 64'd13);
    read_m = 1'b0;
    @(negedge clk);
    chk("rd_release0", 64'({ready0, st0}), 64'({1'b0, IDLE}));
    chk("rd_release1", 64'({ready1, st1}), 64'({1'b0, IDLE}));
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [15:0] data, input logic also_read);
    int n = 0;
    int lat0 = -1;
    int lat1 = -1;
    wexp_q0.push_back({addr, data});
    wexp_q1.push_back({addr, data});
    address_m = addr;
    tb_wdata  = data;
    tb_den    = 1'b1;
    write_m   = 1'b1;
    read_m    = also_read;
    while ((lat0 < 0 || lat1 < 0) && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        address_m = 16'h7777;
        tb_wdata  = 16'h0BAD;
      end
      if (ready0 && lat0 < 0) lat0 = n - 1;
      if (ready1 && lat1 < 0) lat1 = n - 1;
    end
    chk("wr_lat0", 64'(lat0), 64'd1);
    chk("wr_lat1", 64'(lat1), 64'd1);
    write_m = 1'b0;
    read_m  = 1'b0;
    tb_den  = 1'b0;
    @(negedge clk);
    chk("wr_release0", 64'({ready0, st0}), 64'({1'b0, IDLE}));
    chk("wr_release1", 64'({ready1, st1}), 64'({1'b0, IDLE}));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int hold0;
    int hold1;
    reset_n    = 1'b0;
    read_m     = 1'b0;
    write_m    = 1'b0;
    address_m  = 16'h0000;
    tb_wdata   = 16'h0000;
    tb_den     = 1'b0;
    wrap_watch = 1'b0;
    pl_en      = 1'b0;
    pl_addr    = 16'h0000;
    pl_data    = 16'h0000;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      pl_en   = 1'b1;
      pl_addr = PL_TAB[i][31:16];
      pl_data = PL_TAB[i][15:0];
    end
    @(negedge clk);
    pl_en = 1'b0;

    apply_reset();
    chk("rst_ready", 64'(ready0), 64'd0);
    chk("rst_we", 64'(we0), 64'd0);
    chk("rst_addr", 64'(saddr0), 64'd0);
    chk("rst_wdata", 64'(swdata0), 64'd0);
    chk("rst_perr", 64'(perr0), 64'd0);
    chk("rst_state", 64'(st0), 64'(IDLE));
    chk("rst_inst1", 64'({ready1, we1, perr1, st1, saddr1}), 64'd0);

    do_read(16'h0010, 64'h4444_3333_2222_1111);
    do_write(16'h0021, 16'hBEEF, 1'b0);
    do_read(16'h0020, 64'hA3A3_A2A2_BEEF_A0A0);
    chk("perr_clean", 64'({perr0, perr1}), 64'd0);

    do_read(16'h0013, 64'h4444_3333_2222_1111);
    chk("perr_misalign", 64'({perr0, perr1}), 64'b11);

    apply_reset();
    chk("perr_after_rst", 64'({perr0, perr1}), 64'd0);

    do_write(16'h0040, 16'h5A5A, 1'b1);
    chk("perr_conflict", 64'({perr0, perr1}), 64'b11);
    repeat (3) @(negedge clk);
    chk("perr_sticky", 64'({perr0, perr1}), 64'b11);
    chk("conflict_no_read", 64'({st0, st1}), 64'({IDLE, IDLE}));

    // Reset lands in the third cycle of a burst.
    address_m = 16'h0010;
    read_m    = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    read_m  = 1'b0;
    @(negedge clk);
    chk("midrst0", 64'({ready0, we0, perr0, st0}), 64'({3'b000, IDLE}));
    chk("midrst_addr0", 64'(saddr0), 64'd0);
    chk("midrst1", 64'({ready1, we1, perr1, st1, saddr1}), 64'd0);
    reset_n = 1'b1;

    do_read(16'h0010, 64'h4444_3333_2222_1111);
    do_write(16'h0031, 16'h1234, 1'b0);

    wrap_watch = 1'b1;
    do_read(16'hFFFC, 64'hF3F3_F2F2_F1F1_F0F0);
    wrap_watch = 1'b0;

    // Request withdrawn mid-burst: burst still completes, HOLD lasts one cycle.
    exp_q0.push_back(64'hA3A3_A2A2_BEEF_A0A0);
    exp_q1.push_back(64'hA3A3_A2A2_BEEF_A0A0);
    address_m = 16'h0020;
    read_m    = 1'b1;
    repeat (2) @(negedge clk);
    read_m = 1'b0;
    n      = 0;
    hold0  = 0;
    hold1  = 0;
    while (n < 60 && !(hold1 > 0 && st0 == IDLE && st1 == IDLE)) begin
      @(negedge clk);
      n++;
      if (st0 == HOLD) hold0++;
      if (st1 == HOLD) hold1++;
    end
    chk("drop_hold0", 64'(hold0), 64'd1);
    chk("drop_hold1", 64'(hold1), 64'd1);
    chk("drop_idle", 64'({st0, st1}), 64'({IDLE, IDLE}));

    do_write(16'h0032, 16'h5678, 1'b0);

`ifdef MEM_STATS_EN
    chk("rd_count0", 64'(rdc0), 64'd3);
    chk("wr_count0", 64'(wrc0), 64'd2);
    chk("counts1", 64'({rdc1, wrc1}), 64'({16'd3, 16'd2}));
    apply_reset();
    chk("counts_rst", 64'({rdc0, wrc0, rdc1, wrc1}), 64'd0);
`endif

    repeat (2) @(negedge clk);
    chk("exp_q0_left", 64'(exp_q0.size()), 64'd0);
    chk("exp_q1_left", 64'(exp_q1.size()), 64'd0);
    chk("wexp_q0_left", 64'(wexp_q0.size()), 64'd0);
    chk("wexp_q1_left", 64'(wexp_q1.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
